als_somador_subtrator_seq: RTL and testbench
============================================

// Module: als_somador_subtrator_seq
// PURPOSE
//   Parametrised, registered adder/subtractor for the SAP-1 datapath; successor of the
//   8-bit combinational SomadorSubtrator. Adds a valid/ready handshake, a result register,
//   a persistent carry flag for multi-word ADC/SBB chains, and Z/N/V flags.
//   Sits between the A/B registers and the W bus; one operation per accepted transfer.
// PARAMETERS
//   LARGURA  8  operand/result width in bits (>= 2)
//   SATURA   0  1 = clamp signed overflow to max/min; 0 = wrap modulo 2^LARGURA
// PORTS
//   clk        in   1        single clock, all state on rising edge
//   rst        in   1        synchronous, active-high reset
//   in_valid   in   1        operands/controls valid
//   in_ready   out  1        block can accept; transfer when in_valid & in_ready
//   A          in   LARGURA  operand A
//   B          in   LARGURA  operand B
//   Subtrair   in   1        0 = A+B, 1 = A-B
//   UsarCarry  in   1        1 = chained op (ADC/SBB): carry-in from CarryFlag
//   out_valid  out  1        S and flags valid
//   out_ready  in   1        consumer takes result; transfer when out_valid & out_ready
//   S          out  LARGURA  result (registered)
//   Cout       out  1        carry out of bit LARGURA-1 (1 = no borrow when subtracting)
//   Zero       out  1        zero flag (chained across UsarCarry ops, see below)
//   Neg        out  1        S[LARGURA-1]
//   Ovf        out  1        signed overflow (before saturation)
//   CarryFlag  out  1        stored carry, updated on every accepted op
// BEHAVIOUR
//   - Reset (sync, rst=1 at edge): out_valid=0, S=0, Cout=0, Zero=0, Neg=0, Ovf=0,
//     CarryFlag=0; any held result is discarded. in_ready=1 the cycle after reset.
//   - in_ready = !out_valid | out_ready (combinational; one-entry output buffer).
//   - Accept: Bx = B ^ {LARGURA{Subtrair}}; cin = UsarCarry ? CarryFlag : Subtrair;
//     soma[LARGURA:0] = A + Bx + cin (LARGURA+1 bits, no truncation before Cout).
//   - Cout = soma[LARGURA]; Ovf = (A[MSB]==Bx[MSB]) & (soma[MSB]!=A[MSB]).
//   - S = soma[LARGURA-1:0]; if SATURA=1 and Ovf: S = A[MSB] ? 100..0 : 011..1.
//   - Zero = (S==0) & (UsarCarry ? Zero_prev : 1), Zero_prev = last registered Zero.
//   - Neg = S[MSB] after saturation.
//   - On accept: S/flags/CarryFlag load at that edge, out_valid=1. Latency 1 cycle.
//   - Back-to-back: accept in same cycle as out_ready=1 loads new result, out_valid stays 1;
//     the new op sees CarryFlag/Zero of the previous op (already registered).
//   - out_ready=1 with no accept: out_valid -> 0, S and flags hold last values.
//   - out_valid=1, out_ready=0: S/flags/CarryFlag frozen, in_ready=0, inputs ignored.
//   - in_valid=0: no state change (CarryFlag persists across idle cycles).
//   - Reset wins over accept/drain in the same cycle.
// TESTING
//   T1 LARGURA=8, add A=0xAD B=0x6B -> next cycle out_valid=1 S=0x18 Cout=1 Ovf=0 Neg=0
//   T2 sub A=0xAD B=0x6B -> S=0x42 Cout=1 Ovf=1 Zero=0; SATURA=1 build: S=0x80 Neg=1
//   T3 16-bit chain: add 0xFF+0x01 (UsarCarry=0) -> S=0x00 Cout=1 Zero=1; then
//      0x01+0x00 UsarCarry=1 -> S=0x02 Cout=0 Zero=0 (i.e. 0x01FF+0x0001=0x0200)
//   T4 sub A=0x2C B=0x2C -> S=0x00 Zero=1 Cout=1; then SBB 0x00-0x00 UsarCarry=1 -> Zero=1
//   T5 hold out_ready=0 3 cycles with new in_valid -> in_ready=0, S=0x18 stable,
//      CarryFlag unchanged; raise out_ready -> pending input accepted same edge
//   T6 rst=1 while out_valid=1, CarryFlag=1 -> next edge out_valid=0, CarryFlag=0, S=0

Source files
------------

// File: rtl/als_somador_subtrator_seq.sv
// Registered SAP-1 adder/subtractor with a valid/ready handshake and a one-entry output buffer.
// Keeps a carry flag and a zero flag so multi-word ADC/SBB chains can be built from LARGURA-bit ops.
module als_somador_subtrator_seq #(
  parameter int unsigned LARGURA = 8,
  parameter bit          SATURA  = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [LARGURA-1:0] A,
  input  logic [LARGURA-1:0] B,
  input  logic               Subtrair,
  input  logic               UsarCarry,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [LARGURA-1:0] S,
  output logic               Cout,
  output logic               Zero,
  output logic               Neg,
  output logic               Ovf,
  output logic               CarryFlag
);

  localparam int unsigned Msb = LARGURA - 1;

  logic               valid_q, valid_d;
  logic [LARGURA-1:0] s_q, s_d;
  logic               cout_q, cout_d;
  logic               zero_q, zero_d;
  logic               neg_q, neg_d;
  logic               ovf_q, ovf_d;
  logic               carry_q, carry_d;

  logic               accept;
  logic [LARGURA-1:0] bx;
  logic               cin;
  logic [LARGURA:0]   soma;
  logic               ovf_calc;
  logic [LARGURA-1:0] s_calc;

  assign in_ready = !valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  always_comb begin
    bx       = B ^ {LARGURA{Subtrair}};
    cin      = UsarCarry ? carry_q : Subtrair;
    soma     = {1'b0, A} + {1'b0, bx} + {{LARGURA{1'b0}}, cin};
    ovf_calc = (A[Msb] == bx[Msb]) && (soma[Msb] != A[Msb]);
    s_calc   = soma[LARGURA-1:0];
    if (SATURA && ovf_calc) begin
      // Overflow direction follows the operand sign: negative clamps to min, positive to max.
      s_calc = A[Msb] ? {1'b1, {(LARGURA-1){1'b0}}} : {1'b0, {(LARGURA-1){1'b1}}};
    end
  end

  always_comb begin
    valid_d = valid_q;
    s_d     = s_q;
    cout_d  = cout_q;
    zero_d  = zero_q;
    neg_d   = neg_q;
    ovf_d   = ovf_q;
    carry_d = carry_q;
    if (accept) begin
      valid_d = 1'b1;
      s_d     = s_calc;
      cout_d  = soma[LARGURA];
      zero_d  = (s_calc == '0) && (UsarCarry ? zero_q : 1'b1);
      neg_d   = s_calc[Msb];
      ovf_d   = ovf_calc;
      carry_d = soma[LARGURA];
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      s_q     <= '0;
      cout_q  <= 1'b0;
      zero_q  <= 1'b0;
      neg_q   <= 1'b0;
      ovf_q   <= 1'b0;
      carry_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
      s_q     <= s_d;
      cout_q  <= cout_d;
      zero_q  <= zero_d;
      neg_q   <= neg_d;
      ovf_q   <= ovf_d;
      carry_q <= carry_d;
    end
  end

  assign out_valid = valid_q;
  assign S         = s_q;
  assign Cout      = cout_q;
  assign Zero      = zero_q;
  assign Neg       = neg_q;
  assign Ovf       = ovf_q;
  assign CarryFlag = carry_q;

endmodule

// File: tb/tb_als_somador_subtrator_seq.sv
// Bench for als_somador_subtrator_seq: a vector table fed through a scoreboard queue, plus
// hand sequences for back-pressure, reset and a saturating instance sharing the same stimulus.
module tb_als_somador_subtrator_seq;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       sub;
    logic       uc;
    logic [7:0] s;
    logic       c;
    logic       z;
    logic       n;
    logic       v;
    logic [7:0] ss;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       out_ready;
  logic [7:0] A, B;
  logic       Subtrair, UsarCarry;

  logic       in_ready, out_valid, Cout, Zero, Neg, Ovf, CarryFlag;
  logic [7:0] S;
  logic       sat_in_ready, sat_out_valid, sat_cout, sat_zero, sat_neg, sat_ovf, sat_carry;
  logic [7:0] sat_s;

  int   total = 0;
  int   bad   = 0;
  vec_t sb[$];
  vec_t tbl[13];

  always #5 clk = ~clk;

  als_somador_subtrator_seq #(.LARGURA(8), .SATURA(1'b0)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .A(A), .B(B),
    .Subtrair(Subtrair), .UsarCarry(UsarCarry), .out_valid(out_valid), .out_ready(out_ready),
    .S(S), .Cout(Cout), .Zero(Zero), .Neg(Neg), .Ovf(Ovf), .CarryFlag(CarryFlag)
  );

  als_somador_subtrator_seq #(.LARGURA(8), .SATURA(1'b1)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(sat_in_ready), .A(A), .B(B),
    .Subtrair(Subtrair), .UsarCarry(UsarCarry), .out_valid(sat_out_valid),
    .out_ready(out_ready), .S(sat_s), .Cout(sat_cout), .Zero(sat_zero), .Neg(sat_neg),
    .Ovf(sat_ovf), .CarryFlag(sat_carry)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic sub,
                       input logic uc);
    A         = a;
    B         = b;
    Subtrair  = sub;
    UsarCarry = uc;
    in_valid  = 1'b1;
  endtask

  // One cycle: scoreboard check on the falling edge, then advance past the next rising edge.
  task automatic tick();
    vec_t e;
    @(negedge clk);
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_empty: output S=%0h with no expected entry", S);
      end else begin
        e = sb.pop_front();
        chk("S", 32'(S), 32'(e.s));
        chk("Cout", 32'(Cout), 32'(e.c));
        chk("Zero", 32'(Zero), 32'(e.z));
        chk("Neg", 32'(Neg), 32'(e.n));
        chk("Ovf", 32'(Ovf), 32'(e.v));
        chk("CarryFlag", 32'(CarryFlag), 32'(e.c));
        chk("sat_valid", 32'(sat_out_valid), 32'd1);
        chk("sat_ready", 32'(sat_in_ready), 32'd1);
        chk("sat_S", 32'(sat_s), 32'(e.ss));
        chk("sat_Neg", 32'(sat_neg), 32'(e.ss[7]));
        chk("sat_Cout", 32'(sat_cout), 32'(e.c));
        chk("sat_Carry", 32'(sat_carry), 32'(e.c));
        chk("sat_Zero", 32'(sat_zero), 32'(e.z));
        chk("sat_Ovf", 32'(sat_ovf), 32'(e.v));
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    //            a      b     sub uc   s     c  z  n  v  ss
    tbl[0]  = '{8'hAD, 8'h6B, 0, 0, 8'h18, 1, 0, 0, 0, 8'h18};
    tbl[1]  = '{8'hAD, 8'h6B, 1, 0, 8'h42, 1, 0, 0, 1, 8'h80};
    tbl[2]  = '{8'hFF, 8'h01, 0, 0, 8'h00, 1, 1, 0, 0, 8'h00};
    tbl[3]  = '{8'h01, 8'h00, 0, 1, 8'h02, 0, 0, 0, 0, 8'h02};
    tbl[4]  = '{8'h2C, 8'h2C, 1, 0, 8'h00, 1, 1, 0, 0, 8'h00};
    tbl[5]  = '{8'h00, 8'h00, 1, 1, 8'h00, 1, 1, 0, 0, 8'h00};
    tbl[6]  = '{8'h7F, 8'h01, 0, 0, 8'h80, 0, 0, 1, 1, 8'h7F};
    tbl[7]  = '{8'h80, 8'h01, 1, 0, 8'h7F, 1, 0, 0, 1, 8'h80};
    tbl[8]  = '{8'h05, 8'h07, 1, 0, 8'hFE, 0, 0, 1, 0, 8'hFE};
    tbl[9]  = '{8'h10, 8'h01, 1, 1, 8'h0E, 1, 0, 0, 0, 8'h0E};
    tbl[10] = '{8'h00, 8'h00, 0, 1, 8'h01, 0, 0, 0, 0, 8'h01};
    tbl[11] = '{8'h00, 8'h00, 0, 1, 8'h00, 0, 0, 0, 0, 8'h00};
    tbl[12] = '{8'h00, 8'h00, 0, 0, 8'h00, 0, 1, 0, 0, 8'h00};

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    A         = 8'h00;
    B         = 8'h00;
    Subtrair  = 1'b0;
    UsarCarry = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_S", 32'(S), 32'd0);
    chk("rst_Cout", 32'(Cout), 32'd0);
    chk("rst_Zero", 32'(Zero), 32'd0);
    chk("rst_Neg", 32'(Neg), 32'd0);
    chk("rst_Ovf", 32'(Ovf), 32'd0);
    chk("rst_CarryFlag", 32'(CarryFlag), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // Back-to-back stream; carry and zero chain through consecutive entries.
    for (int i = 0; i < 13; i++) begin
      drive(tbl[i].a, tbl[i].b, tbl[i].sub, tbl[i].uc);
      sb.push_back(tbl[i]);
      tick();
      chk("stream_valid", 32'(out_valid), 32'd1);
    end
    in_valid = 1'b0;
    tick();
    chk("drain_valid", 32'(out_valid), 32'd0);

    // Back-pressure: result held, new input waits, then accepted on the draining edge.
    out_ready = 1'b0;
    drive(8'hAD, 8'h6B, 1'b0, 1'b0);
    sb.push_back('{8'hAD, 8'h6B, 0, 0, 8'h18, 1, 0, 0, 0, 8'h18});
    tick();
    drive(8'h05, 8'h07, 1'b1, 1'b1);
    sb.push_back('{8'h05, 8'h07, 1, 1, 8'hFE, 0, 0, 1, 0, 8'hFE});
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("hold_in_ready", 32'(in_ready), 32'd0);
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_S", 32'(S), 32'h18);
      chk("hold_CarryFlag", 32'(CarryFlag), 32'd1);
    end
    out_ready = 1'b1;
    tick();
    chk("b2b_S", 32'(S), 32'hFE);
    chk("b2b_valid", 32'(out_valid), 32'd1);
    in_valid = 1'b0;
    tick();
    chk("idle_valid", 32'(out_valid), 32'd0);
    chk("idle_S_hold", 32'(S), 32'hFE);
    chk("idle_Neg_hold", 32'(Neg), 32'd1);
    tick();
    chk("idle_carry_hold", 32'(CarryFlag), 32'd0);

    // Reset beats a simultaneous accept and drain.
    out_ready = 1'b0;
    drive(8'hFF, 8'h01, 1'b0, 1'b0);
    tick();
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    chk("pre_rst_carry", 32'(CarryFlag), 32'd1);
    rst       = 1'b1;
    out_ready = 1'b1;
    drive(8'h01, 8'h01, 1'b0, 1'b0);
    tick();
    chk("rst2_valid", 32'(out_valid), 32'd0);
    chk("rst2_carry", 32'(CarryFlag), 32'd0);
    chk("rst2_S", 32'(S), 32'd0);
    chk("rst2_Cout", 32'(Cout), 32'd0);
    chk("rst2_Zero", 32'(Zero), 32'd0);
    rst = 1'b0;
    // Chained op right after reset: carry-in 0 and Zero_prev 0.
    drive(8'h00, 8'h00, 1'b0, 1'b1);
    sb.push_back('{8'h00, 8'h00, 0, 1, 8'h00, 0, 0, 0, 0, 8'h00});
    tick();
    in_valid = 1'b0;
    tick();
    chk("end_valid", 32'(out_valid), 32'd0);
    chk("sb_drain", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
